// File: rtl/comm_fifo_pkg.sv
// -----------------------------------------------------------------------------
// comm_fifo_pkg
//   Shared helpers for the clock-crossing FIFOs:
//     bin2gray / gray2bin : pointer code conversion, operating on a 32-bit
//                           container. Callers zero-extend narrower pointers
//                           and truncate the result back to their width.
//                           Zero extension keeps the low bits exact in both
//                           directions.
//     params_ok           : legality check that the FIFO top evaluates at
//                           elaboration time.
// -----------------------------------------------------------------------------
package comm_fifo_pkg;

  localparam int CODE_W = 32;

  function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] g);
    logic [CODE_W-1:0] b;
    b[CODE_W-1] = g[CODE_W-1];
    for (int i = CODE_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // DEPTH must be a power of two (>= 4), at least two synchronizer flops,
  // and both occupancy thresholds inside 0..DEPTH.
  function automatic bit params_ok(input int depth, input int sync_stages,
                                   input int af, input int ae);
    return (depth >= 4) && ((depth & (depth - 1)) == 0) &&
           (sync_stages >= 2) &&
           (af >= 0) && (af <= depth) &&
           (ae >= 0) && (ae <= depth);
  endfunction

endpackage

// File: rtl/async_fifo_lvl_gray_sync.sv
// -----------------------------------------------------------------------------
// gray_sync
//   Multi-flop synchronizer for a Gray-coded pointer entering i_clk's domain.
//   Only one bit of the input changes per source update, so the captured
//   word is always either the old or the new pointer.
//   Ports:
//     i_clk  destination clock
//     i_rst  destination synchronous reset, active-high
//     i_d    Gray pointer from the source domain
//     o_q    synchronized pointer (STAGES destination cycles of delay)
// -----------------------------------------------------------------------------
module gray_sync #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] r_sync [STAGES];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/async_fifo_lvl.sv
// -----------------------------------------------------------------------------
// async_fifo_lvl
//   Dual-clock FIFO with registered full/empty, almost flags and occupancy
//   levels on each side. Pointers are AW+1 bits (wrap at 2*DEPTH); only Gray
//   pointers cross domains, each through a gray_sync instance.
//   Ports (write domain, w_clk):
//     w_rst        synchronous active-high reset
//     w_en/w_data  write request / payload; accepted when w_en && !full
//     full, almost_full, w_level  (level over-estimates occupancy)
//   Ports (read domain, r_clk):
//     r_rst        synchronous active-high reset
//     r_en         read request; accepted when r_en && !empty
//     r_data       registered payload, valid the cycle after acceptance
//     r_valid      high exactly on that cycle
//     empty, almost_empty, r_level (level under-estimates occupancy)
//   Build option: ASYNC_FIFO_LVL_ERR_EN adds sticky overflow (w_clk) and
//   underflow (r_clk) outputs, cleared only by their own reset.
//   Both resets must be asserted together for SYNC_STAGES+1 slow-clock cycles.
// -----------------------------------------------------------------------------
module async_fifo_lvl
  import comm_fifo_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = DEPTH - 2,
  parameter int AE_THRESH   = 2
) (
  input  logic                   w_clk,
  input  logic                   w_rst,
  input  logic                   r_clk,
  input  logic                   r_rst,
  input  logic                   w_en,
  input  logic [DATA_W-1:0]      w_data,
  output logic                   full,
  output logic                   almost_full,
  output logic [$clog2(DEPTH):0] w_level,
  input  logic                   r_en,
  output logic [DATA_W-1:0]      r_data,
  output logic                   r_valid,
  output logic                   empty,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] r_level
`ifdef ASYNC_FIFO_LVL_ERR_EN
  ,
  output logic                   overflow,
  output logic                   underflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AF_L = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_L = PW'(AE_THRESH);

  if (!params_ok(DEPTH, SYNC_STAGES, AF_THRESH, AE_THRESH)) begin : g_param_err
    $error("async_fifo_lvl: illegal DEPTH / SYNC_STAGES / threshold parameters");
  end

  // Storage is intentionally not reset; pointers define what is valid.
  logic [DATA_W-1:0] r_mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Write domain
  // ---------------------------------------------------------------------------
  logic          w_push;
  logic [PW-1:0] w_bin;
  logic [PW-1:0] w_gray;
  logic [PW-1:0] w_bin_next;
  logic [PW-1:0] w_gray_next;
  logic [PW-1:0] w_rq_gray;
  logic [PW-1:0] w_rq_bin;
  logic [PW-1:0] w_level_next;
  logic          w_full_next;

  logic [PW-1:0] r_gray;

  gray_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync_r2w (
    .i_clk (w_clk),
    .i_rst (w_rst),
    .i_d   (r_gray),
    .o_q   (w_rq_gray)
  );

  assign w_push       = w_en && !full;
  assign w_bin_next   = w_bin + {{AW{1'b0}}, w_push};
  assign w_gray_next  = PW'(bin2gray(CODE_W'(w_bin_next)));
  assign w_rq_bin     = PW'(gray2bin(CODE_W'(w_rq_gray)));
  // Full: write pointer one lap ahead of the read pointer. In Gray code that
  // is the two MSBs inverted and the rest equal.
  assign w_full_next  = (w_gray_next == {~w_rq_gray[PW-1:PW-2], w_rq_gray[PW-3:0]});
  // Stale read pointer makes this an over-estimate, bounded by DEPTH.
  assign w_level_next = w_bin_next - w_rq_bin;

  always_ff @(posedge w_clk) begin
    if (w_push) r_mem[w_bin[AW-1:0]] <= w_data;
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      w_bin       <= '0;
      w_gray      <= '0;
      full        <= 1'b0;
      almost_full <= (AF_THRESH == 0);
      w_level     <= '0;
    end else begin
      w_bin       <= w_bin_next;
      w_gray      <= w_gray_next;
      full        <= w_full_next;
      almost_full <= (w_level_next >= AF_L);
      w_level     <= w_level_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Read domain
  // ---------------------------------------------------------------------------
  logic          r_pop;
  logic [PW-1:0] r_bin;
  logic [PW-1:0] r_bin_next;
  logic [PW-1:0] r_gray_next;
  logic [PW-1:0] r_wq_gray;
  logic [PW-1:0] r_wq_bin;
  logic [PW-1:0] r_level_next;
  logic          r_empty_next;

  gray_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync_w2r (
    .i_clk (r_clk),
    .i_rst (r_rst),
    .i_d   (w_gray),
    .o_q   (r_wq_gray)
  );

  assign r_pop        = r_en && !empty;
  assign r_bin_next   = r_bin + {{AW{1'b0}}, r_pop};
  assign r_gray_next  = PW'(bin2gray(CODE_W'(r_bin_next)));
  assign r_wq_bin     = PW'(gray2bin(CODE_W'(r_wq_gray)));
  assign r_empty_next = (r_gray_next == r_wq_gray);
  // Stale write pointer makes this an under-estimate.
  assign r_level_next = r_wq_bin - r_bin_next;

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      r_bin        <= '0;
      r_gray       <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      r_level      <= '0;
      r_valid      <= 1'b0;
      r_data       <= '0;
    end else begin
      r_bin        <= r_bin_next;
      r_gray       <= r_gray_next;
      empty        <= r_empty_next;
      almost_empty <= (r_level_next <= AE_L);
      r_level      <= r_level_next;
      r_valid      <= r_pop;
      if (r_pop) r_data <= r_mem[r_bin[AW-1:0]];
    end
  end

`ifdef ASYNC_FIFO_LVL_ERR_EN
  // Sticky error flags; only the owning reset clears them.
  always_ff @(posedge w_clk) begin
    if (w_rst)              overflow <= 1'b0;
    else if (w_en && full)  overflow <= 1'b1;
  end

  always_ff @(posedge r_clk) begin
    if (r_rst)              underflow <= 1'b0;
    else if (r_en && empty) underflow <= 1'b1;
  end
`endif

endmodule
